imem_loader: RTL and testbench

- Producer side of the cpu's flat `instruction_stream` bus.
- Receives a program as a byte-serial valid/ready stream and assembles big-endian 32-bit instruction words.
- Writes word i into bits [32i+31:32i] of the flat image.
- Holds the cpu in reset until the program load completes, then releases it.
- Sits between the host/boot interface and the cpu's `instruction_stream` and `rst` inputs.

---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-serial program loader: assembles big-endian 32-bit words into a flat
// instruction image and holds the cpu in reset until the load completes.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DEPTH*32-1:0]   instruction_stream,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      word_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] word_count_reg, word_count_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [31:0]      asm_reg, asm_next;
    logic             error_reg, error_next;

    logic             accept;
    logic             load_start;
    logic             word_wr;
    logic             at_last_slot;
    logic [31:0]      word_val;

    assign accept       = (state_reg == ST_LOAD) && in_valid;
    assign load_start   = start && (state_reg != ST_LOAD);
    assign word_wr      = accept && ((byte_idx_reg == 2'd3) || in_last);
    assign at_last_slot = (word_count_reg == CNT_W'(DEPTH - 1));

    // Byte k of a word lands at bit offset (3-k)*8; unreceived low bytes stay zero.
    assign word_val = asm_reg | ({24'd0, in_data} << {~byte_idx_reg, 3'b000});

    always_comb begin
        state_next      = state_reg;
        word_count_next = word_count_reg;
        byte_idx_next   = byte_idx_reg;
        asm_next        = asm_reg;
        error_next      = error_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next      = ST_LOAD;
                    word_count_next = '0;
                    byte_idx_next   = 2'd0;
                    asm_next        = 32'd0;
                    error_next      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (word_wr) begin
                        asm_next        = 32'd0;
                        byte_idx_next   = 2'd0;
                        word_count_next = word_count_reg + CNT_W'(1);
                        if (in_last) begin
                            state_next = ST_DONE;
                            error_next = (byte_idx_reg != 2'd3);
                        end else if (at_last_slot) begin
                            state_next = ST_DONE;
                            error_next = 1'b1;
                        end
                    end else begin
                        asm_next      = word_val;
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            word_count_reg <= '0;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= 32'd0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_count_reg <= word_count_next;
            byte_idx_reg   <= byte_idx_next;
            asm_reg        <= asm_next;
            error_reg      <= error_next;
        end
    end

    // One register per slot so each word has its own write decode and clear.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [31:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst || load_start) begin
                    slot_reg <= 32'd0;
                end else if (word_wr && (word_count_reg == CNT_W'(gi))) begin
                    slot_reg <= word_val;
                end
            end
            assign instruction_stream[gi*32 +: 32] = slot_reg;
        end
    endgenerate

    assign in_ready   = (state_reg == ST_LOAD);
    assign busy       = (state_reg == ST_LOAD);
    assign done       = (state_reg == ST_DONE);
    assign cpu_rst    = (state_reg != ST_DONE);
    assign error      = error_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (DEPTH=4): stimulus queues expected load
// results, a monitor checks them whenever done rises.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int IW    = DEPTH * 32;

    localparam logic [IW-1:0] IMG_BASIC   = {32'h0, 32'h20020007, 32'h00210820, 32'h20010002};
    localparam logic [IW-1:0] IMG_PARTIAL = {32'h0, 32'h0, 32'hEEFF0000, 32'hAABBCCDD};
    localparam logic [IW-1:0] IMG_OVF     = {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
    localparam logic [IW-1:0] IMG_RELOAD  = {32'h0, 32'h0, 32'h0, 32'h0000000C};

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_last;
    logic [7:0]       in_data;
    logic             in_ready, cpu_rst, busy, done, error;
    logic [IW-1:0]    instruction_stream;
    logic [CNT_W-1:0] word_count;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .instruction_stream(instruction_stream),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] image;
        int            wc;
        bit            err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] prog_q[$];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [IW-1:0] img, input int wc, input bit err);
        exp_t e;
        e.image = img;
        e.wc    = wc;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compare a completed load against the oldest expectation.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 required no completion");
            end else begin
                e = exp_q.pop_front();
                chk("sb_image", instruction_stream, e.image);
                chk("sb_word_count", IW'(word_count), IW'(e.wc));
                chk("sb_error", IW'(error), IW'(e.err));
            end
        end
        $display("txn t=%0t done=%0b busy=%0b in_ready=%0b cpu_rst=%0b wc=%0d err=%0b",
                 $time, done, busy, in_ready, cpu_rst, word_count, error);
        done_prev = done;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required 1", n);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_prog(input int max_gap, input bit use_last);
        for (int i = 0; i < prog_q.size(); i++) begin
            send_byte(prog_q[i], use_last && (i == prog_q.size() - 1),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_released(input string tag);
        chk({tag, "_done"}, IW'(done), IW'(1));
        chk({tag, "_cpu_rst"}, IW'(cpu_rst), IW'(0));
        chk({tag, "_in_ready"}, IW'(in_ready), IW'(0));
    endtask

    task automatic load_basic(input int max_gap);
        prog_q = '{8'h20, 8'h01, 8'h00, 8'h02, 8'h00, 8'h21, 8'h08, 8'h20,
                   8'h20, 8'h02, 8'h00, 8'h07};
        pulse_start();
        chk("load_cpu_rst", IW'(cpu_rst), IW'(1));
        chk("load_busy", IW'(busy), IW'(1));
        chk("load_in_ready", IW'(in_ready), IW'(1));
        push_exp(IMG_BASIC, 3, 1'b0);
        run_prog(max_gap, 1'b1);
        check_released("basic");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_image", instruction_stream, '0);
        chk("rst_word_count", IW'(word_count), IW'(0));
        chk("rst_cpu_rst", IW'(cpu_rst), IW'(1));
        chk("rst_in_ready", IW'(in_ready), IW'(0));
        chk("rst_busy_done_err", IW'({busy, done, error}), IW'(0));

        // Bytes offered while idle are ignored.
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("idle_ignore_wc", IW'(word_count), IW'(0));
        chk("idle_ignore_done", IW'(done), IW'(0));

        load_basic(0);
        repeat (3) @(negedge clk);
        chk("basic_hold_in_ready", IW'(in_ready), IW'(0));

        // Reload from DONE with a stray start during LOAD.
        pulse_start();
        chk("reload_cpu_rst", IW'(cpu_rst), IW'(1));
        chk("reload_done_low", IW'(done), IW'(0));
        push_exp(IMG_RELOAD, 1, 1'b0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        pulse_start();
        chk("start_in_load_busy", IW'(busy), IW'(1));
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h0C, 1'b1, 0);
        check_released("reload");

        load_basic(3);

        prog_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        pulse_start();
        push_exp(IMG_PARTIAL, 2, 1'b1);
        run_prog(0, 1'b1);
        check_released("partial");

        // Overflow: 16 bytes with no in_last fill all four slots.
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(8'(i));
        pulse_start();
        push_exp(IMG_OVF, 4, 1'b1);
        run_prog(0, 1'b0);
        check_released("ovf");
        in_valid = 1'b1; in_data = 8'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ovf_no_ready", IW'(in_ready), IW'(0));
        end
        in_valid = 1'b0;
        chk("ovf_wc_hold", IW'(word_count), IW'(4));
        chk("ovf_image_hold", instruction_stream, IMG_OVF);

        // Reset in the middle of a load.
        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pulse_start();
        run_prog(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_image", instruction_stream, '0);
        chk("midrst_wc", IW'(word_count), IW'(0));
        chk("midrst_cpu_rst", IW'(cpu_rst), IW'(1));
        chk("midrst_in_ready", IW'(in_ready), IW'(0));
        chk("midrst_busy", IW'(busy), IW'(0));

        // rst and start together: reset wins.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", IW'(busy), IW'(0));

        load_basic(0);

        repeat (3) @(negedge clk);
        chk("sb_pending", IW'(exp_q.size()), IW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
